serialparalelo_idl: RTL and testbench



---
 rtl/serialparalelo_idl_if.sv | 26 ++
 rtl/serialparalelo_idl.sv | 134 +++++++++++++
 tb/tb_serialparalelo_idl.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serialparalelo_idl_if.sv
// Serial receive bus for the IDL serial-to-parallel converter.
// slave: converter side (consumes the serial bit, drives the recovered byte stream).
// master: upstream/observer side.
interface serialparalelo_idl_if;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic       IDL;

  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  active,
    input  IDL
  );

  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output active,
    output IDL
  );
endinterface

// File: rtl/serialparalelo_idl.sv
// Receive-side serial-to-parallel converter on the clk_32f domain.
// Finds byte boundaries from the comma symbol, goes active after BC_COUNT
// consecutive aligned commas, then delivers bytes with a one-cycle strobe
// and flags idle symbols on IDL.
// Optional feature macro: SP_IDL_FILTER_EN -- when defined, idle symbols
// raise IDL only and are not strobed onto data_out.
module serialparalelo_idl #(
  parameter logic [7:0]  COMMA    = 8'hBC,
  parameter logic [7:0]  IDL_CODE = 8'h7C,
  parameter int unsigned BC_COUNT = 4
) (
  input logic                 clk_32f,
  input logic                 reset,
  serialparalelo_idl_if.slave bus
);

  typedef enum logic [1:0] {
    SEARCH,
    ALIGN,
    ACTIVE
  } state_t;

  state_t     state, state_n;
  // Only the seven newest bits of the previous window survive into the next
  // window, so the oldest shift-register bit is never stored.
  logic [6:0] sr, sr_n;
  logic [2:0] bc_cnt, bc_n;
  logic [3:0] k_cnt, k_n;
  logic [7:0] data_r, data_n;
  logic       valid_r, valid_n;
  logic       active_r, active_n;
  logic       idl_r, idl_n;

  logic [7:0] w;
  logic       byte_done;
  logic [3:0] k_inc;

  assign w         = {sr, bus.data_in};
  assign byte_done = (bc_cnt == 3'd7);
  assign k_inc     = k_cnt + 4'd1;

  // State and datapath registers, cleared asynchronously by reset.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state    <= SEARCH;
      sr       <= '0;
      bc_cnt   <= '0;
      k_cnt    <= '0;
      data_r   <= '0;
      valid_r  <= 1'b0;
      active_r <= 1'b0;
      idl_r    <= 1'b0;
    end else begin
      state    <= state_n;
      sr       <= sr_n;
      bc_cnt   <= bc_n;
      k_cnt    <= k_n;
      data_r   <= data_n;
      valid_r  <= valid_n;
      active_r <= active_n;
      idl_r    <= idl_n;
    end
  end

  // Next-state: comma search, alignment counting and byte classification.
  always_comb begin
    state_n  = state;
    sr_n     = w[6:0];
    bc_n     = bc_cnt;
    k_n      = k_cnt;
    data_n   = data_r;
    valid_n  = 1'b0;
    active_n = active_r;
    idl_n    = idl_r;

    case (state)
      SEARCH: begin
        if (w == COMMA) begin
          bc_n = '0;
          k_n  = 4'd1;
          if (BC_COUNT == 1) begin
            state_n  = ACTIVE;
            active_n = 1'b1;
          end else begin
            state_n = ALIGN;
          end
        end
      end

      ALIGN: begin
        bc_n = bc_cnt + 3'd1;
        if (byte_done) begin
          if (w == COMMA) begin
            k_n = k_inc;
            if (k_inc == 4'(BC_COUNT)) begin
              state_n  = ACTIVE;
              active_n = 1'b1;
            end
          end else begin
            k_n     = '0;
            state_n = SEARCH;
          end
        end
      end

      ACTIVE: begin
        bc_n = bc_cnt + 3'd1;
        if (byte_done) begin
          if (w == COMMA) begin
            idl_n = 1'b0;
          end else if (w == IDL_CODE) begin
            idl_n = 1'b1;
`ifndef SP_IDL_FILTER_EN
            data_n  = w;
            valid_n = 1'b1;
`endif
          end else begin
            data_n  = w;
            valid_n = 1'b1;
            idl_n   = 1'b0;
          end
        end
      end

      default: state_n = SEARCH;
    endcase
  end

  assign bus.data_out  = data_r;
  assign bus.valid_out = valid_r;
  assign bus.active    = active_r;
  assign bus.IDL       = idl_r;

endmodule

// File: tb/tb_serialparalelo_idl.sv
// Self-checking bench for serialparalelo_idl: directed scenarios plus a
// randomized byte stream, all checked per edge against a bit-count model.
module tb_serialparalelo_idl;

  localparam logic [7:0] COMMA = 8'hBC;
  localparam logic [7:0] IDLC  = 8'h7C;
  localparam int         BCN   = 4;

  logic clk_32f = 1'b0;
  logic reset   = 1'b0;
  always #5 clk_32f = ~clk_32f;

  serialparalelo_idl_if bus();

  serialparalelo_idl #(
    .COMMA   (COMMA),
    .IDL_CODE(IDLC),
    .BC_COUNT(BCN)
  ) dut (
    .clk_32f(clk_32f),
    .reset  (reset),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: counts bits since reset and frames bytes by arithmetic
  // on the bit index of the first aligned comma.
  logic [7:0] m_hist;
  int         m_n, m_align_at, m_commas;
  bit         m_aligned;
  logic       m_active, m_idl, m_valid;
  logic [7:0] m_data;

  logic [10:0] obs, expv;
  logic        bits[$];

  function automatic void model_reset();
    m_hist = '0; m_n = 0; m_align_at = 0; m_commas = 0; m_aligned = 0;
    m_active = 0; m_idl = 0; m_valid = 0; m_data = '0;
  endfunction

  function automatic void model_edge(input logic b);
    m_hist  = {m_hist[6:0], b};
    m_n     = m_n + 1;
    m_valid = 0;
    if (!m_aligned) begin
      if (m_hist == COMMA) begin
        m_aligned  = 1;
        m_align_at = m_n;
        m_commas   = 1;
        if (m_commas == BCN) m_active = 1;
      end
    end else if (((m_n - m_align_at) % 8) == 0) begin
      if (!m_active) begin
        if (m_hist == COMMA) begin
          m_commas = m_commas + 1;
          if (m_commas == BCN) m_active = 1;
        end else begin
          m_aligned = 0;
        end
      end else if (m_hist == COMMA) begin
        m_idl = 0;
      end else if (m_hist == IDLC) begin
        m_idl = 1;
`ifndef SP_IDL_FILTER_EN
        m_data  = m_hist;
        m_valid = 1;
`endif
      end else begin
        m_data  = m_hist;
        m_valid = 1;
        m_idl   = 0;
      end
    end
  endfunction

  function automatic void add_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) bits.push_back(b[i]);
  endfunction

  task automatic send_bit(input logic b);
    @(negedge clk_32f);
    bus.data_in = b;
    @(posedge clk_32f);
    #1;
    model_edge(b);
    obs  = {bus.active, bus.IDL, bus.valid_out, bus.data_out};
    expv = {m_active, m_idl, m_valid, m_data};
  endtask

  task automatic apply_reset(input int n);
    @(negedge clk_32f);
    reset = 1'b1;
    bus.data_in = 1'b0;
    repeat (n) @(posedge clk_32f);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk_32f);
    bus.data_in = 1'b1;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.active, bus.IDL, bus.valid_out, bus.data_out} !== 11'b0) begin
      failures++;
      $display("FAIL reset_async: got %h, want 000", {bus.active, bus.IDL, bus.valid_out, bus.data_out});
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_32f);
      #1;
      checks++;
      if ({bus.active, bus.IDL, bus.valid_out, bus.data_out} !== 11'b0) begin
        failures++;
        $display("FAIL reset_hold cycle %0d: got %h, want 000", c, {bus.active, bus.IDL, bus.valid_out, bus.data_out});
      end
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_align_basic();
    int rise = -1;
    int vcnt = 0;
    apply_reset(3);
    bits.delete();
    repeat (4) add_byte(COMMA);
    foreach (bits[i]) begin
      send_bit(bits[i]);
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL align_basic bit %0d: got %h, want %h", i + 1, obs, expv);
      end
      if (bus.active === 1'b1 && rise < 0) rise = i + 1;
      if (bus.valid_out === 1'b1) vcnt++;
    end
    checks++;
    if (rise !== 32) begin
      failures++;
      $display("FAIL align_basic_rise: got bit %0d, want bit 32", rise);
    end
    checks++;
    if (vcnt !== 0) begin
      failures++;
      $display("FAIL align_basic_nostrobe: got %0d pulses, want 0", vcnt);
    end
  endtask

  task automatic test_data_after_align();
    int rise = -1;
    int vcnt = 0;
    int vat = -1;
    logic [7:0] vdata = '0;
    apply_reset(2);
    bits.delete();
    repeat (3) bits.push_back(1'($urandom_range(0, 1)));
    repeat (4) add_byte(COMMA);
    add_byte(8'h55);
    foreach (bits[i]) begin
      send_bit(bits[i]);
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL data_after_align bit %0d: got %h, want %h", i + 1, obs, expv);
      end
      if (bus.active === 1'b1 && rise < 0) rise = i + 1;
      if (bus.valid_out === 1'b1) begin
        vcnt++;
        vat = i + 1;
        vdata = bus.data_out;
      end
    end
    checks++;
    if (rise !== 35) begin
      failures++;
      $display("FAIL data_rise: got bit %0d, want bit 35", rise);
    end
    checks++;
    if (vcnt !== 1 || vat !== 43 || vdata !== 8'h55) begin
      failures++;
      $display("FAIL data_strobe: got pulses=%0d at=%0d data=%h, want 1 at 43 data=55", vcnt, vat, vdata);
    end
  endtask

  task automatic test_broken_run();
    int rise = -1;
    apply_reset(2);
    bits.delete();
    repeat (3) add_byte(COMMA);
    add_byte(8'hA0);
    repeat (4) add_byte(COMMA);
    foreach (bits[i]) begin
      send_bit(bits[i]);
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL broken_run bit %0d: got %h, want %h", i + 1, obs, expv);
      end
      if (bus.active === 1'b1 && rise < 0) rise = i + 1;
    end
    checks++;
    if (rise !== 64) begin
      failures++;
      $display("FAIL broken_run_rise: got bit %0d, want bit 64", rise);
    end
  endtask

  task automatic test_idle();
    int idl_hi = 0;
    int vcnt = 0;
    int want_v;
    logic [7:0] last = '0;
`ifdef SP_IDL_FILTER_EN
    want_v = 1;
`else
    want_v = 2;
`endif
    apply_reset(2);
    bits.delete();
    repeat (4) add_byte(COMMA);
    add_byte(IDLC);
    add_byte(8'h12);
    add_byte(COMMA);
    foreach (bits[i]) begin
      send_bit(bits[i]);
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL idle bit %0d: got %h, want %h", i + 1, obs, expv);
      end
      if (bus.IDL === 1'b1) idl_hi++;
      if (bus.valid_out === 1'b1) begin
        vcnt++;
        last = bus.data_out;
      end
    end
    checks++;
    if (idl_hi !== 8) begin
      failures++;
      $display("FAIL idle_width: got %0d cycles, want 8", idl_hi);
    end
    checks++;
    if (vcnt !== want_v || last !== 8'h12) begin
      failures++;
      $display("FAIL idle_strobes: got pulses=%0d last=%h, want %0d last=12", vcnt, last, want_v);
    end
  endtask

  task automatic test_reset_mid();
    int rise = -1;
    apply_reset(2);
    bits.delete();
    repeat (4) add_byte(COMMA);
    add_byte(8'h12);
    bits.push_back(1'b0);
    bits.push_back(1'b0);
    bits.push_back(1'b1);
    foreach (bits[i]) begin
      send_bit(bits[i]);
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL reset_mid_pre bit %0d: got %h, want %h", i + 1, obs, expv);
      end
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.active, bus.IDL, bus.valid_out, bus.data_out} !== 11'b0) begin
      failures++;
      $display("FAIL reset_mid_async: got %h, want 000", {bus.active, bus.IDL, bus.valid_out, bus.data_out});
    end
    @(posedge clk_32f);
    #1;
    reset = 1'b0;
    model_reset();
    bits.delete();
    repeat (4) add_byte(COMMA);
    foreach (bits[i]) begin
      send_bit(bits[i]);
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL reset_mid_post bit %0d: got %h, want %h", i + 1, obs, expv);
      end
      if (bus.active === 1'b1 && rise < 0) rise = i + 1;
    end
    checks++;
    if (rise !== 32) begin
      failures++;
      $display("FAIL reset_mid_realign: got bit %0d, want bit 32", rise);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    apply_reset(2);
    bits.delete();
    repeat (5) add_byte(8'($urandom));
    repeat (4) add_byte(COMMA);
    repeat (24) begin
      case ($urandom_range(0, 3))
        0: b = COMMA;
        1: b = IDLC;
        default: b = 8'($urandom);
      endcase
      add_byte(b);
    end
    foreach (bits[i]) begin
      send_bit(bits[i]);
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL random bit %0d: got %h, want %h", i + 1, obs, expv);
      end
    end
  endtask

  initial begin
    bus.data_in = 1'b0;
    test_reset();
    test_align_basic();
    test_data_after_align();
    test_broken_run();
    test_idle();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
